// File: rtl/airplane_pkg.sv
// Shared constants, FSM encoding, sprite mask and row-clamp helper for the player-plane controller.
package airplane_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int MASK_W   = 8;
  localparam int MASK_H   = 4;

  localparam logic [2:0] COLOUR_BG    = 3'b000;
  localparam logic [2:0] COLOUR_PLANE = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ERASE = 2'd1,
    S_MOVE  = 2'd2,
    S_DRAW  = 2'd3
  } state_t;

  // Bit (py*MASK_W + px) is pixel (px, py); row 0 sits in the low byte.
  localparam logic [MASK_W*MASK_H-1:0] PLANE_MASK = {
    8'b0011_1100,
    8'b0001_1000,
    8'b1111_1111,
    8'b0001_1011
  };

  // Clamped move; 8-bit arithmetic keeps subtraction below zero and overshoot past ymax from wrapping.
  function automatic logic [6:0] move_row(input logic [6:0] y, input logic up, input logic down,
                                          input logic [7:0] step, input logic [7:0] ymax);
    logic [7:0] y8;
    logic [7:0] sum8;
    y8   = {1'b0, y};
    sum8 = y8 + step;
    if (up && !down) begin
      y8 = (y8 >= step) ? (y8 - step) : 8'd0;
    end else if (down && !up) begin
      y8 = (sum8 > ymax) ? ymax : sum8;
    end else begin
      y8 = y8;
    end
    return y8[6:0];
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame-rate divider: counts 0..FRAME_DIV-1 and raises a registered one-cycle tick at each wrap.
module frame_tick_gen
  import airplane_pkg::*;
#(
  parameter int FRAME_DIV = 833334
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int            CW   = $clog2(FRAME_DIV);
  localparam logic [CW-1:0] LAST = CW'(FRAME_DIV - 1);

  logic [CW-1:0] cnt_r;

  // Free-running frame counter with registered wrap strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
      tick  <= 1'b0;
    end else begin
      tick  <= (cnt_r == LAST);
      cnt_r <= (cnt_r == LAST) ? '0 : cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/plane_sprite_ctrl.sv
// Player-plane sprite controller: on each frame tick erase the sprite, move it one step, redraw it.
// Optional build macro PLANE_SHAPE_EN draws the package silhouette mask instead of a solid rectangle.
module plane_sprite_ctrl
  import airplane_pkg::*;
#(
  parameter int         SCREEN_H     = 120,
  parameter int         SPR_W        = 8,
  parameter int         SPR_H        = 4,
  parameter int         X_POS        = 16,
  parameter int         STEP         = 1,
  parameter int         FRAME_DIV    = 833334,
  parameter logic [2:0] PLANE_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR    = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       up,
  input  logic       down,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic [6:0] plane_y
);

  localparam int            NPIX     = SPR_W * SPR_H;
  localparam int            IW       = $clog2(NPIX);
  localparam int            PXW      = $clog2(SPR_W);
  localparam logic [6:0]    Y_INIT   = 7'((SCREEN_H - SPR_H) / 2);
  localparam logic [7:0]    Y_MAX8   = 8'(SCREEN_H - SPR_H);
  localparam logic [7:0]    STEP8    = 8'(STEP);
  localparam logic [IW-1:0] LAST_IDX = IW'(NPIX - 1);

  state_t        state_r;
  logic [IW-1:0] idx_r;
  logic          pending_r;
  logic          tick_s;
  logic [7:0]    pix_x_s;
  logic [6:0]    pix_y_s;
  logic [2:0]    draw_colour_s;
  logic          last_pix_s;

  frame_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick_s)
  );

  // Pixel index splits row-major into px (low bits) and py (high bits).
  always_comb begin
    pix_x_s    = 8'(X_POS) + {{(8-PXW){1'b0}}, idx_r[PXW-1:0]};
    pix_y_s    = plane_y + {{(7-(IW-PXW)){1'b0}}, idx_r[IW-1:PXW]};
    last_pix_s = (idx_r == LAST_IDX);
  end

  // Draw-phase colour: solid sprite, or silhouette mask when the shape option is built.
  always_comb begin
`ifdef PLANE_SHAPE_EN
    draw_colour_s = PLANE_MASK[idx_r] ? PLANE_COLOUR : BG_COLOUR;
`else
    draw_colour_s = PLANE_COLOUR;
`endif
  end

  // Frame FSM with registered pixel outputs; reset lands in S_DRAW so the sprite appears at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_DRAW;
      idx_r     <= '0;
      pending_r <= 1'b0;
      plane_y   <= Y_INIT;
      plot      <= 1'b0;
      x_out     <= 8'd0;
      y_out     <= 7'd0;
      colour    <= 3'd0;
      busy      <= 1'b1;
    end else begin
      if (tick_s && (state_r != S_IDLE)) begin
        pending_r <= 1'b1;
      end
      case (state_r)
        S_IDLE: begin
          plot <= 1'b0;
          if (tick_s || pending_r) begin
            state_r   <= S_ERASE;
            pending_r <= 1'b0;
            idx_r     <= '0;
            busy      <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        S_ERASE: begin
          plot   <= 1'b1;
          x_out  <= pix_x_s;
          y_out  <= pix_y_s;
          colour <= BG_COLOUR;
          idx_r  <= last_pix_s ? '0 : idx_r + {{(IW-1){1'b0}}, 1'b1};
          if (last_pix_s) begin
            state_r <= S_MOVE;
          end
        end
        S_MOVE: begin
          plot    <= 1'b0;
          plane_y <= move_row(plane_y, up, down, STEP8, Y_MAX8);
          state_r <= S_DRAW;
        end
        S_DRAW: begin
          plot   <= 1'b1;
          x_out  <= pix_x_s;
          y_out  <= pix_y_s;
          colour <= draw_colour_s;
          idx_r  <= last_pix_s ? '0 : idx_r + {{(IW-1){1'b0}}, 1'b1};
          if (last_pix_s) begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r <= S_IDLE;
          plot    <= 1'b0;
          busy    <= 1'b0;
          idx_r   <= '0;
        end
      endcase
    end
  end

endmodule
